// File: rtl/mem_arb_pkg.sv
// Shared types and port identifiers for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins,
// and a tie goes to the port that was not served last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      pick = ~last;
    end else if (req[1]) begin
      pick = PORT_DMA;
    end else begin
      pick = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses to one fixed-latency memory with
// round-robin arbitration, one access in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADRW    = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [ADRW-1:0]  adr0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             req1,
  input  logic             we1,
  input  logic [ADRW-1:0]  adr1,
  input  logic [WIDTH-1:0] wd1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ADRW-1:0]  mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT);

  arb_state_t      state_q;
  logic            last_q;
  logic            owner_q;
  logic            we_q;
  logic [CW-1:0]   cnt_q;

  logic            pick_valid;
  logic            pick;
  logic            sel_we;
  logic [ADRW-1:0] sel_adr;
  logic [WIDTH-1:0] sel_wd;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    sel_we  = pick ? we1  : we0;
    sel_adr = pick ? adr1 : adr0;
    sel_wd  = pick ? wd1  : wd0;
    if (state_q == IDLE && pick_valid) begin
      gnt0 = (pick == PORT_CPU);
      gnt1 = (pick == PORT_DMA);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      mem_adr <= '0;
      mem_wd  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick;
            we_q    <= sel_we;
            mem_adr <= sel_adr;
            mem_wd  <= sel_wd;
            last_q  <= pick;
            cnt_q   <= '0;
            mem_en  <= 1'b1;
            mem_we  <= sel_we;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (we_q || cnt_q == CNT_LAST) begin
            if (!we_q) begin
              if (owner_q == PORT_DMA) rd1 <= mem_rd;
              else                     rd0 <= mem_rd;
            end
            done0   <= (owner_q == PORT_CPU);
            done1   <= (owner_q == PORT_DMA);
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ADRW    = 32;
  localparam int unsigned MEM_LAT = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, we0, req1, we1;
  logic [ADRW-1:0]  adr0, adr1;
  logic [WIDTH-1:0] wd0, wd1;
  logic             gnt0, gnt1, done0, done1;
  logic [WIDTH-1:0] rd0, rd1;
  logic             mem_en, mem_we;
  logic [ADRW-1:0]  mem_adr;
  logic [WIDTH-1:0] mem_wd, mem_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .ADRW(ADRW), .MEM_LAT(MEM_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .we0     (we0),
    .adr0    (adr0),
    .wd0     (wd0),
    .req1    (req1),
    .we1     (we1),
    .adr1    (adr1),
    .wd1     (wd1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done0   (done0),
    .done1   (done1),
    .rd0     (rd0),
    .rd1     (rd1),
    .mem_en  (mem_en),
    .mem_we  (mem_we),
    .mem_adr (mem_adr),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  function automatic logic [31:0] init_word(input int a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Memory device: data appears exactly MEM_LAT edges after the strobe, garbage otherwise.
  logic        mem_init = 1'b1;
  logic [31:0] dev_mem [256];
  logic        pv [MEM_LAT];
  logic [7:0]  pa [MEM_LAT];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      dev_mem[mem_adr[7:0]] <= mem_wd;
    end
    pv[0] <= mem_en && !mem_we;
    pa[0] <= mem_adr[7:0];
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign mem_rd = pv[MEM_LAT-1] ? dev_mem[pa[MEM_LAT-1]] : 32'hBAD0_BAD0;

  // Reference model state
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rd [2];
  logic        last_m;
  logic        p_we [2];
  logic [31:0] p_adr [2];
  logic [31:0] p_wd [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    we0 = p_we[0]; adr0 = p_adr[0]; wd0 = p_wd[0];
    we1 = p_we[1]; adr1 = p_adr[1]; wd1 = p_wd[1];
  endtask

  task automatic randomize_port(input int p);
    p_we[p]  = 1'($urandom_range(0, 1));
    p_adr[p] = 32'($urandom_range(0, 15));
    p_wd[p]  = $urandom;
  endtask

  task automatic model_reset();
    last_m    = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_strobes", 32'({gnt1, gnt0, done1, done0, mem_en, mem_we}), 32'h0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_adr", mem_adr, 32'h0);
    reset = 1'b1;
    model_reset();
  endtask

  // One access, from the gnt cycle to the done cycle.
  task automatic run_txn(input logic r0, input logic r1, input logic keep, input logic pulse1);
    logic pick;
    int   lat;
    @(negedge clk);
    req0 = r0; req1 = r1;
    drive_data();
    #1;
    pick = (r0 && r1) ? !last_m : r1;
    chk("gnt", 32'({gnt1, gnt0}), pick ? 32'h2 : 32'h1);
    lat = p_we[pick] ? 2 : MEM_LAT + 2;
    if (p_we[pick]) ref_mem[p_adr[pick][7:0]] = p_wd[pick];
    else            exp_rd[pick] = ref_mem[p_adr[pick][7:0]];
    @(negedge clk);
    if (!keep) begin
      if (pick) req1 = 1'b0;
      else      req0 = 1'b0;
    end
    if (pulse1) req1 = 1'b1;
    #1;
    chk("mem_en_we", 32'({mem_en, mem_we}), 32'({1'b1, p_we[pick]}));
    chk("mem_adr", mem_adr, p_adr[pick]);
    if (p_we[pick]) chk("mem_wd", mem_wd, p_wd[pick]);
    chk("gnt_c1", 32'({gnt1, gnt0}), 32'h0);
    for (int c = 2; c <= lat; c++) begin
      @(negedge clk);
      if (pulse1 && c == 2) req1 = 1'b0;
      #1;
      chk("gnt_busy", 32'({gnt1, gnt0}), 32'h0);
      chk("done", 32'({done1, done0}), (c == lat) ? (pick ? 32'h2 : 32'h1) : 32'h0);
      if (c < lat) chk("mem_en_busy", 32'(mem_en), 32'h0);
    end
    chk("rd0", rd0, exp_rd[0]);
    chk("rd1", rd1, exp_rd[1]);
    last_m = pick;
    randomize_port(int'(pick));
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int p = 0; p < 2; p++) randomize_port(p);
    drive_data();
    model_reset();
    @(negedge clk);
    mem_init = 1'b0;

    // Idle after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_quiet", 32'({gnt1, gnt0, done1, done0, mem_en}), 32'h0);
    end

    // CPU read of 0x40
    p_we[0] = 1'b0; p_adr[0] = 32'h40;
    run_txn(1'b1, 1'b0, 1'b0, 1'b0);
    chk("cpu_read_val", rd0, 32'hDEAD_BEEF);

    // DMA write of 0x1234 to 0x10
    p_we[1] = 1'b1; p_adr[1] = 32'h10; p_wd[1] = 32'h1234;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0);

    // Both ports requesting continuously: strict alternation starting with port 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk("alt_order", 32'(last_m), (i % 2 == 0) ? 32'h1 : 32'h0);
      run_txn(1'b1, 1'b1, 1'b1, 1'b0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset during a read aborts it
    do_reset();
    p_we[0] = 1'b0; p_adr[0] = 32'h3;
    @(negedge clk);
    req0 = 1'b1; drive_data();
    #1;
    chk("abort_gnt", 32'(gnt0), 32'h1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk("abort_en_pre", 32'(mem_en), 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_en_now", 32'(mem_en), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b1;
      #1;
      chk("abort_no_done", 32'({done1, done0, mem_en}), 32'h0);
    end
    model_reset();
    chk("abort_rd0", rd0, 32'h0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0);

    // DMA pulse during CPU busy is forgotten
    p_we[0] = 1'b0;
    run_txn(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      #1;
      chk("pulse_ignored", 32'({gnt1, gnt0, mem_en}), 32'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
